// File: rtl/alu_issue_ctrl.sv
// ID->EX issue stage: ALU control decode, operand select/forward, ID/EX register and FP hold-off FSM.
// Optional feature macro: FWD_EN (MEM/WB -> ID operand forwarding); default build issues register-file data directly.
module alu_issue_ctrl #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int FP_LAT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic            flush,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            opb5,
  input  logic            ALUSrc,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_regwrite,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [2:0]      ALUControl,
  output logic            fp_op,
  output logic            fp_busy,
  output logic            fp_done
);

  localparam int CNT_W = 4;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    FP_WAIT = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_SLT  = 3'd5,
    ALU_PASS = 3'd7
  } alu_ctrl_t;

  if (FP_LAT < 1 || FP_LAT > 15) begin : g_bad_fp_lat
    $error("alu_issue_ctrl: FP_LAT must be in 1..15");
  end

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic            accept;
  alu_ctrl_t       dec_ctrl;
  logic            dec_fp;
  logic [XLEN-1:0] fwd_a, fwd_b, opnd_b;

  // ---------------------------------------------------------------------------
  // ALU control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven in an always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    dec_ctrl = ALU_ADD;
    dec_fp   = 1'b0;
    unique case (ALUOp)
      2'b00: dec_ctrl = ALU_ADD;
      2'b01: dec_ctrl = ALU_SUB;
      2'b10: begin
        unique case (funct3)
          3'b000:  dec_ctrl = (funct7b5 && opb5) ? ALU_SUB : ALU_ADD;
          3'b010:  dec_ctrl = ALU_SLT;
          3'b110:  dec_ctrl = ALU_OR;
          3'b111:  dec_ctrl = ALU_AND;
          default: dec_ctrl = ALU_ADD;
        endcase
      end
      2'b11: begin
        dec_ctrl = ALU_AND;
        dec_fp   = 1'b1;
      end
      default: dec_ctrl = ALU_ADD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand selection
  // ---------------------------------------------------------------------------
`ifdef FWD_EN
  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  always_comb begin
    fwd_a = rs1_data;
    if (mem_regwrite && (mem_rd == rs1) && (mem_rd != '0))
      fwd_a = mem_result;
    else if (wb_regwrite && (wb_rd == rs1) && (wb_rd != '0))
      fwd_a = wb_result;
  end

  always_comb begin
    fwd_b = rs2_data;
    if (mem_regwrite && (mem_rd == rs2) && (mem_rd != '0))
      fwd_b = mem_result;
    else if (wb_regwrite && (wb_rd == rs2) && (wb_rd != '0))
      fwd_b = wb_result;
  end
`else
  assign fwd_a = rs1_data;
  assign fwd_b = rs2_data;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{rs1, rs2, mem_rd, mem_regwrite, mem_result,
                               wb_rd, wb_regwrite, wb_result};
`endif

  assign opnd_b = ALUSrc ? imm : fwd_b;

  // ---------------------------------------------------------------------------
  // Issue FSM: RUN accepts; FP_WAIT holds off issue while the FPA completes
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    id_ready  = 1'b0;
    accept    = 1'b0;
    fp_busy   = 1'b0;
    fp_done   = 1'b0;

    unique case (state)
      RUN: begin
        id_ready = !flush;
        accept   = id_valid && id_ready;
        if (accept && dec_fp) begin
          state_nxt = FP_WAIT;
          cnt_nxt   = CNT_W'(FP_LAT - 1);
        end
      end
      FP_WAIT: begin
        fp_busy = 1'b1;
        if (cnt == '0) begin
          fp_done   = !flush;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase

    // A squash abandons any pending FP wait without signalling completion.
    if (flush) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // ID/EX boundary register
  // ---------------------------------------------------------------------------
  // NOTE: the operand/control registers are reset too, because the reset value
  // of every output is visible to EX and must be defined, not left as X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      a          <= '0;
      b          <= '0;
      ALUControl <= 3'd0;
      fp_op      <= 1'b0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        a          <= fwd_a;
        b          <= opnd_b;
        ALUControl <= dec_ctrl;
        fp_op      <= dec_fp;
      end else if (flush) begin
        fp_op <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus randomized traffic against a
// reference model that tracks FP hold-off as "first edge at which issue may resume".
module tb_alu_issue_ctrl;

  localparam int XLEN   = 32;
  localparam int RA_W   = 5;
  localparam int FP_LAT = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid, id_ready, flush;
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic            funct7b5, opb5, ALUSrc;
  logic [RA_W-1:0] rs1, rs2, mem_rd, wb_rd;
  logic [XLEN-1:0] rs1_data, rs2_data, imm, mem_result, wb_result;
  logic            mem_regwrite, wb_regwrite;
  logic            ex_valid, fp_op, fp_busy, fp_done;
  logic [XLEN-1:0] a, b;
  logic [2:0]      ALUControl;

  alu_issue_ctrl #(.XLEN(XLEN), .RA_W(RA_W), .FP_LAT(FP_LAT)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready), .flush(flush),
    .ALUOp(ALUOp), .funct3(funct3), .funct7b5(funct7b5), .opb5(opb5), .ALUSrc(ALUSrc),
    .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
    .ex_valid(ex_valid), .a(a), .b(b), .ALUControl(ALUControl), .fp_op(fp_op),
    .fp_busy(fp_busy), .fp_done(fp_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: edges are numbered; issue is allowed at edge k iff k >= resume.
  int              cyc    = 0;
  int              resume = 0;
  logic            m_ex_valid, m_fp;
  logic [XLEN-1:0] m_a, m_b;
  logic [2:0]      m_ctrl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s at edge %0d: got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [2:0] ref_ctrl();
    if (ALUOp == 2'd0) return 3'd0;
    if (ALUOp == 2'd1) return 3'd1;
    if (ALUOp == 2'd3) return 3'd2;
    if (funct3 == 3'b010) return 3'd5;
    if (funct3 == 3'b110) return 3'd3;
    if (funct3 == 3'b111) return 3'd2;
    if (funct3 == 3'b000 && funct7b5 && opb5) return 3'd1;
    return 3'd0;
  endfunction

  function automatic logic [XLEN-1:0] ref_src(input logic [RA_W-1:0] rs, input logic [XLEN-1:0] rf);
`ifdef FWD_EN
    if (rs != 0 && mem_regwrite && mem_rd == rs) return mem_result;
    if (rs != 0 && wb_regwrite && wb_rd == rs) return wb_result;
`endif
    return rf;
  endfunction

  task automatic model_reset();
    resume     = 0;
    m_ex_valid = 1'b0;
    m_fp       = 1'b0;
    m_a        = '0;
    m_b        = '0;
    m_ctrl     = 3'd0;
  endtask

  task automatic check_regs(input string pfx);
    check({pfx, "_ex_valid"}, ex_valid, m_ex_valid);
    check({pfx, "_a"}, a, m_a);
    check({pfx, "_b"}, b, m_b);
    check({pfx, "_ctrl"}, ALUControl, m_ctrl);
    check({pfx, "_fp_op"}, fp_op, m_fp);
  endtask

  // Inputs are already driven (at a negedge); checks handshake outputs, clocks one edge,
  // advances the model and checks the ID/EX register. Returns at the next negedge.
  task automatic cycle_check(input string pfx);
    bit busy, rdy, done, acc;
    #1;
    busy = (cyc < resume);
    rdy  = !busy && !flush;
    done = busy && (cyc == resume - 1) && !flush;
    acc  = id_valid && rdy;
    check({pfx, "_id_ready"}, id_ready, rdy);
    check({pfx, "_fp_busy"}, fp_busy, busy);
    check({pfx, "_fp_done"}, fp_done, done);
    @(posedge clk);
    m_ex_valid = acc;
    if (acc) begin
      m_a    = ref_src(rs1, rs1_data);
      m_b    = ALUSrc ? imm : ref_src(rs2, rs2_data);
      m_ctrl = ref_ctrl();
      m_fp   = (ALUOp == 2'd3);
      if (m_fp) resume = cyc + FP_LAT + 1;
    end
    if (flush) begin
      m_fp   = 1'b0;
      resume = cyc + 1;
    end
    cyc++;
    #1;
    check_regs(pfx);
    @(negedge clk);
  endtask

  task automatic apply_reset(input string pfx);
    reset = 1'b1;
    #1;
    model_reset();
    check({pfx, "_id_ready"}, id_ready, 1'b1);
    check({pfx, "_fp_busy"}, fp_busy, 1'b0);
    check({pfx, "_fp_done"}, fp_done, 1'b0);
    check_regs(pfx);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_idle();
    id_valid = 0; flush = 0; ALUOp = 0; funct3 = 0; funct7b5 = 0; opb5 = 0; ALUSrc = 0;
    rs1 = 0; rs2 = 0; rs1_data = 0; rs2_data = 0; imm = 0;
    mem_rd = 0; mem_regwrite = 0; mem_result = 0; wb_rd = 0; wb_regwrite = 0; wb_result = 0;
  endtask

  task automatic drive_random();
    int r;
    r            = $urandom_range(0, 9);
    ALUOp        = (r == 0) ? 2'd3 : 2'(r % 3);
    id_valid     = ($urandom_range(0, 9) < 8);
    flush        = ($urandom_range(0, 24) == 0);
    funct3       = 3'($urandom);
    funct7b5     = 1'($urandom);
    opb5         = 1'($urandom);
    ALUSrc       = 1'($urandom);
    rs1          = RA_W'($urandom_range(0, 3));
    rs2          = RA_W'($urandom_range(0, 3));
    mem_rd       = RA_W'($urandom_range(0, 3));
    wb_rd        = RA_W'($urandom_range(0, 3));
    mem_regwrite = 1'($urandom);
    wb_regwrite  = 1'($urandom);
    rs1_data     = $urandom;
    rs2_data     = $urandom;
    imm          = $urandom;
    mem_result   = $urandom;
    wb_result    = $urandom;
  endtask

  initial begin
    drive_idle();
    model_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    apply_reset("rst");

    // R-type SUB, plain register operands
    id_valid = 1; ALUOp = 2'b10; funct3 = 3'b000; funct7b5 = 1; opb5 = 1;
    rs1 = 1; rs2 = 2; rs1_data = 9; rs2_data = 4;
    cycle_check("sub");
    check("sub_ctrl_lit", ALUControl, 3'd1);
    check("sub_a_lit", a, 32'd9);
    check("sub_b_lit", b, 32'd4);

    // Forwarding priority: MEM over WB, x0-destination never forwards
    ALUOp = 2'b00; rs1 = 5; rs1_data = 32'h33;
    mem_rd = 5; mem_regwrite = 1; mem_result = 32'h11;
    wb_rd = 5; wb_regwrite = 1; wb_result = 32'h22;
    cycle_check("fwd_mem");
`ifdef FWD_EN
    check("fwd_mem_lit", a, 32'h11);
`else
    check("fwd_off_lit", a, 32'h33);
`endif
    mem_rd = 0;
    cycle_check("fwd_wb");
`ifdef FWD_EN
    check("fwd_wb_lit", a, 32'h22);
`else
    check("fwd_off2_lit", a, 32'h33);
`endif
    rs1 = 0; wb_rd = 0; mem_rd = 0;
    cycle_check("fwd_x0");
    check("fwd_x0_lit", a, 32'h33);
    drive_idle();

    // FP op: issue blocked for FP_LAT edges, fp_done on the last wait cycle
    id_valid = 1; ALUOp = 2'b11;
    cycle_check("fp");
    check("fp_ctrl_lit", ALUControl, 3'd2);
    check("fp_op_lit", fp_op, 1'b1);
    ALUOp = 2'b00;
    repeat (FP_LAT + 2) cycle_check("fp_hold");

    // FP op then flush two cycles later
    ALUOp = 2'b11;
    cycle_check("fpf");
    ALUOp = 2'b00;
    cycle_check("fpf_w");
    flush = 1;
    cycle_check("fpf_flush");
    check("fpf_fp_op_lit", fp_op, 1'b0);
    flush = 0;
    cycle_check("fpf_after");

    // Reset in the middle of FP_WAIT
    ALUOp = 2'b11;
    cycle_check("fpr");
    ALUOp = 2'b00;
    cycle_check("fpr_w");
    apply_reset("fpr_rst");
    cycle_check("fpr_after");

    // SLT with immediate operand, back-to-back issue
    ALUOp = 2'b10; funct3 = 3'b010; ALUSrc = 1; imm = 32'hFFFF_FFFF; id_valid = 1;
    repeat (4) cycle_check("slt");
    check("slt_b_lit", b, 32'hFFFF_FFFF);
    check("slt_ctrl_lit", ALUControl, 3'd5);

    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cycle_check("rnd");
      if (i == 1500) apply_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
